// File: rtl/quad_velocity_decoder.sv
// Quadrature encoder front end: synchronizes and glitch-filters A/B, decodes
// x4 steps into a wrapping signed position, and reports a saturated signed
// step count once per fixed gate window.
module quad_velocity_decoder #(
  parameter int GATE_CYCLES = 120000,
  parameter int CNT_W       = 16,
  parameter int FILT        = 3
) (
  input  logic                    Clk,
  input  logic                    i_Reset_n,
  input  logic                    i_A,
  input  logic                    i_B,
  input  logic                    i_clear,
  output logic signed [CNT_W-1:0] o_position,
  output logic signed [CNT_W-1:0] o_velocity,
  output logic                    o_velocity_valid,
  output logic                    o_step,
  output logic                    o_dir,
  output logic                    o_error
);

  localparam int FC_W = (FILT < 2) ? 1 : $clog2(FILT);
  localparam int GT_W = $clog2(GATE_CYCLES);
  localparam logic [FC_W-1:0] FILT_LAST = FC_W'(FILT - 1);
  localparam logic [GT_W-1:0] GATE_LAST = GT_W'(GATE_CYCLES - 1);
  localparam logic signed [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  // Bit 1 carries channel A, bit 0 channel B.
  logic [1:0]             s1_ab;
  logic [1:0]             s2_ab;
  logic [1:0]             filt_ab;
  logic [1:0]             prev_ab;
  logic [FC_W-1:0]        filt_cnt [2];
  logic [1:0]             fill;
  logic [FC_W-1:0]        arm_cnt;
  logic                   armed;
  logic                   filt_chg;
  logic                   quiet;
  logic [1:0]             ph_diff;
  logic                   step_fwd;
  logic                   step_rev;
  logic                   step_any;
  logic                   illegal;
  logic [GT_W-1:0]        gate_cnt;
  logic                   gate_tc;
  logic signed [CNT_W-1:0] acc;
  logic signed [CNT_W-1:0] acc_next;

  // Position of an AB pattern along the forward cycle 00->10->11->01.
  function automatic logic [1:0] ab_phase(input logic [1:0] ab);
    case (ab)
      2'b00:   ab_phase = 2'd0;
      2'b10:   ab_phase = 2'd1;
      2'b11:   ab_phase = 2'd2;
      default: ab_phase = 2'd3;
    endcase
  endfunction

  // One accumulator step that sticks at the signed limits instead of wrapping.
  function automatic logic signed [CNT_W-1:0] sat_step(
    input logic signed [CNT_W-1:0] val,
    input logic                    up
  );
    if (up) sat_step = (val == ACC_MAX) ? val : val + ONE;
    else    sat_step = (val == ACC_MIN) ? val : val - ONE;
  endfunction

  // Two-flop synchronizer for both encoder channels.
  always_ff @(posedge Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      s1_ab <= '0;
      s2_ab <= '0;
    end else begin
      s1_ab <= {i_A, i_B};
      s2_ab <= s1_ab;
    end
  end

  // Per-channel filter: adopt s2 only after FILT consecutive differing cycles.
  always_ff @(posedge Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      filt_ab     <= '0;
      filt_cnt[0] <= '0;
      filt_cnt[1] <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (s2_ab[ch] == filt_ab[ch]) begin
          filt_cnt[ch] <= '0;
        end else if (filt_cnt[ch] == FILT_LAST) begin
          filt_ab[ch]  <= s2_ab[ch];
          filt_cnt[ch] <= '0;
        end else begin
          filt_cnt[ch] <= filt_cnt[ch] + 1'b1;
        end
      end
    end
  end

  // The filter is only trusted as quiet once the synchronizer holds real samples.
  assign quiet    = fill[1] && (s2_ab == filt_ab);
  assign filt_chg = (filt_ab != prev_ab);

  // Arming: first filtered change or FILT quiet cycles after reset enable decoding.
  always_ff @(posedge Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      fill    <= '0;
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      fill <= {fill[0], 1'b1};
      if (!armed) begin
        if (filt_chg) begin
          armed <= 1'b1;
        end else if (!quiet) begin
          arm_cnt <= '0;
        end else if (arm_cnt == FILT_LAST) begin
          armed <= 1'b1;
        end else begin
          arm_cnt <= arm_cnt + 1'b1;
        end
      end
    end
  end

  assign ph_diff = ab_phase(filt_ab) - ab_phase(prev_ab);

  // x4 decode of previous versus current filtered state.
  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    illegal  = 1'b0;
    if (armed && filt_chg) begin
      case (ph_diff)
        2'd1:    step_fwd = 1'b1;
        2'd3:    step_rev = 1'b1;
        2'd2:    illegal  = 1'b1;
        default: ;
      endcase
    end
  end

  assign step_any = step_fwd | step_rev;
  assign gate_tc  = (gate_cnt == GATE_LAST);
  assign acc_next = step_any ? sat_step(acc, step_fwd) : acc;

  // Step outputs and wrapping position; clear discards a coincident step.
  always_ff @(posedge Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      prev_ab    <= '0;
      o_step     <= 1'b0;
      o_dir      <= 1'b0;
      o_error    <= 1'b0;
      o_position <= '0;
    end else begin
      prev_ab <= filt_ab;
      o_step  <= step_any;
      o_error <= illegal;
      if (step_any) o_dir <= step_fwd;
      if (i_clear)       o_position <= '0;
      else if (step_fwd) o_position <= o_position + ONE;
      else if (step_rev) o_position <= o_position - ONE;
    end
  end

  // Gate timer and window accumulator; clear outranks the terminal count.
  always_ff @(posedge Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      gate_cnt         <= '0;
      acc              <= '0;
      o_velocity       <= '0;
      o_velocity_valid <= 1'b0;
    end else if (i_clear) begin
      gate_cnt         <= '0;
      acc              <= '0;
      o_velocity_valid <= 1'b0;
    end else if (gate_tc) begin
      gate_cnt         <= '0;
      acc              <= '0;
      o_velocity       <= acc_next;
      o_velocity_valid <= 1'b1;
    end else begin
      gate_cnt         <= gate_cnt + 1'b1;
      acc              <= acc_next;
      o_velocity_valid <= 1'b0;
    end
  end

endmodule
